// File: rtl/if_fetch_stage_if.sv
// Instruction-memory bus between the fetch stage and the instruction memory.
// The fetch stage drives the address; the memory returns the word in the same cycle.
interface if_fetch_stage_if #(
    parameter int PC_W    = 8,
    parameter int INSTR_W = 16
);
    logic [PC_W-1:0]    imem_addr;
    logic [INSTR_W-1:0] imem_data;

    modport master (output imem_addr, input imem_data);
    modport slave  (input imem_addr, output imem_data);
endinterface

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, addresses instruction memory and
// registers the fetched word into the IF/ID pipeline register. Handles
// load-use stalls, EX branch redirects, flushes and a HALT opcode.
module if_fetch_stage #(
    parameter int                 PC_W        = 8,
    parameter int                 INSTR_W     = 16,
    parameter int                 PC_STEP     = 2,
    parameter logic [PC_W-1:0]    RESET_PC    = 8'h00,
    parameter logic [3:0]         HALT_OPCODE = 4'hF,
    parameter logic [INSTR_W-1:0] NOP_INSTR   = 16'h0000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall,
    input  logic               flush,
    input  logic               branch_taken,
    input  logic [PC_W-1:0]    branch_target,
    if_fetch_stage_if.master   imem,
    output logic [PC_W-1:0]    pc,
    output logic [INSTR_W-1:0] if_id_instr,
    output logic [PC_W-1:0]    if_id_pc_plus,
    output logic               if_id_valid,
    output logic               halted
);

    typedef enum logic [0:0] {
        ST_FETCH = 1'b0,
        ST_HALT  = 1'b1
    } state_t;

    state_t             state_r;
    logic [PC_W-1:0]    pc_r;
    logic [INSTR_W-1:0] instr_r;
    logic [PC_W-1:0]    pc_plus_r;
    logic               valid_r;
    logic               halted_r;

    logic [PC_W-1:0]    pc_next_seq_s;
    logic [PC_W-1:0]    target_s;
    logic               is_halt_s;

    // Sequential PC wraps modulo 2^PC_W; branch targets are forced to even addresses.
    assign pc_next_seq_s = pc_r + PC_W'(PC_STEP);
    assign target_s      = branch_target & {{(PC_W-1){1'b1}}, 1'b0};
    assign is_halt_s     = (imem.imem_data[INSTR_W-1 -: 4] == HALT_OPCODE);

    assign imem.imem_addr = pc_r;
    assign pc             = pc_r;
    assign if_id_instr    = instr_r;
    assign if_id_pc_plus  = pc_plus_r;
    assign if_id_valid    = valid_r;
    assign halted         = halted_r;

    // Fetch/halt state machine updating the PC and the IF/ID register each edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r   <= ST_FETCH;
            halted_r  <= 1'b0;
            pc_r      <= RESET_PC;
            instr_r   <= NOP_INSTR;
            pc_plus_r <= {PC_W{1'b0}};
            valid_r   <= 1'b0;
        end else begin
            case (state_r)
                ST_FETCH: begin
                    if (branch_taken) begin
                        // Redirect wins over stall and flush.
                        pc_r      <= target_s;
                        instr_r   <= NOP_INSTR;
                        pc_plus_r <= {PC_W{1'b0}};
                        valid_r   <= 1'b0;
                    end else if (stall) begin
                        if (flush) begin
                            instr_r   <= NOP_INSTR;
                            pc_plus_r <= {PC_W{1'b0}};
                            valid_r   <= 1'b0;
                        end else begin
                            pc_r <= pc_r;
                        end
                    end else if (flush) begin
                        pc_r      <= pc_next_seq_s;
                        instr_r   <= NOP_INSTR;
                        pc_plus_r <= {PC_W{1'b0}};
                        valid_r   <= 1'b0;
                    end else begin
                        instr_r   <= imem.imem_data;
                        pc_plus_r <= pc_next_seq_s;
                        valid_r   <= 1'b1;
                        if (is_halt_s) begin
                            // HALT word goes to decode; PC parks on it.
                            state_r  <= ST_HALT;
                            halted_r <= 1'b1;
                        end else begin
                            pc_r <= pc_next_seq_s;
                        end
                    end
                end
                ST_HALT: begin
                    if (branch_taken) begin
                        // The halt was on the wrong path; resume at the target.
                        state_r   <= ST_FETCH;
                        halted_r  <= 1'b0;
                        pc_r      <= target_s;
                        instr_r   <= NOP_INSTR;
                        pc_plus_r <= {PC_W{1'b0}};
                        valid_r   <= 1'b0;
                    end else if (stall) begin
                        pc_r <= pc_r;
                    end else begin
                        instr_r   <= NOP_INSTR;
                        pc_plus_r <= {PC_W{1'b0}};
                        valid_r   <= 1'b0;
                    end
                end
                default: begin
                    state_r   <= ST_FETCH;
                    halted_r  <= 1'b0;
                    instr_r   <= NOP_INSTR;
                    pc_plus_r <= {PC_W{1'b0}};
                    valid_r   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: directed scenarios plus a randomized run, all
// checked against a behavioural model of the fetch rules.
module tb_if_fetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        flush;
    logic        branch_taken;
    logic [7:0]  branch_target;
    logic [7:0]  pc;
    logic [15:0] if_id_instr;
    logic [7:0]  if_id_pc_plus;
    logic        if_id_valid;
    logic        halted;

    logic [15:0] imem [256];

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [7:0]  m_pc;
    logic [15:0] m_instr;
    logic [7:0]  m_pcp;
    logic        m_valid;
    logic        m_halt;

    if_fetch_stage_if #(.PC_W(8), .INSTR_W(16)) bus ();
    assign bus.imem_data = imem[bus.imem_addr];

    if_fetch_stage dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .flush         (flush),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .imem          (bus),
        .pc            (pc),
        .if_id_instr   (if_id_instr),
        .if_id_pc_plus (if_id_pc_plus),
        .if_id_valid   (if_id_valid),
        .halted        (halted)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_pc = 8'h00; m_instr = 16'h0000; m_pcp = 8'h00; m_valid = 1'b0; m_halt = 1'b0;
    endtask

    // One clock edge of the fetch rules, evaluated with plain arithmetic.
    task automatic model_edge(input logic s, input logic f, input logic b, input logic [7:0] t);
        logic [15:0] w;
        w = imem[m_pc];
        if (b) begin
            m_pc = {t[7:1], 1'b0}; m_instr = 16'h0000; m_valid = 1'b0; m_halt = 1'b0;
        end else if (s) begin
            if (f && !m_halt) begin m_instr = 16'h0000; m_valid = 1'b0; end
        end else if (m_halt) begin
            m_instr = 16'h0000; m_valid = 1'b0;
        end else if (f) begin
            m_pc = m_pc + 8'd2; m_instr = 16'h0000; m_valid = 1'b0;
        end else begin
            m_instr = w; m_pcp = m_pc + 8'd2; m_valid = 1'b1;
            if (w[15:12] == 4'hF) m_halt = 1'b1;
            else m_pc = m_pc + 8'd2;
        end
    endtask

    task automatic step(input logic s, input logic f, input logic b, input logic [7:0] t);
        stall = s; flush = f; branch_taken = b; branch_target = t;
        model_edge(s, f, b, t);
        @(posedge clk);
        #1;
    endtask

    task automatic fill_seq();
        for (int i = 0; i < 256; i++) imem[i] = 16'h1000 | 16'(i);
    endtask

    task automatic do_reset();
        stall = 1'b0; flush = 1'b0; branch_taken = 1'b0; branch_target = 8'h00;
        rst = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic test_reset();
        fill_seq();
        imem[0] = 16'h1234; imem[2] = 16'h5678;
        stall = 1'b0; flush = 1'b0; branch_taken = 1'b0; branch_target = 8'h00;
        rst = 1'b0; model_reset();
        #1;
        total++; if (pc !== 8'h00) begin bad++; $display("FAIL reset_pc got=%h want=%h", pc, 8'h00); end
        total++; if (if_id_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", if_id_valid); end
        total++; if (if_id_instr !== 16'h0000) begin bad++; $display("FAIL reset_instr got=%h want=0000", if_id_instr); end
        total++; if (halted !== 1'b0) begin bad++; $display("FAIL reset_halted got=%b want=0", halted); end
        total++; if (if_id_pc_plus !== 8'h00) begin bad++; $display("FAIL reset_pcplus got=%h want=00", if_id_pc_plus); end
        @(posedge clk); #1; rst = 1'b1;
        step(1'b0, 1'b0, 1'b0, 8'h00);
        total++; if (if_id_instr !== 16'h1234) begin bad++; $display("FAIL e1_instr got=%h want=1234", if_id_instr); end
        total++; if (if_id_pc_plus !== 8'h02) begin bad++; $display("FAIL e1_pcplus got=%h want=02", if_id_pc_plus); end
        total++; if (if_id_valid !== 1'b1) begin bad++; $display("FAIL e1_valid got=%b want=1", if_id_valid); end
        total++; if (pc !== 8'h02) begin bad++; $display("FAIL e1_pc got=%h want=02", pc); end
        step(1'b0, 1'b0, 1'b0, 8'h00);
        total++; if (if_id_instr !== 16'h5678) begin bad++; $display("FAIL e2_instr got=%h want=5678", if_id_instr); end
        total++; if (pc !== 8'h04) begin bad++; $display("FAIL e2_pc got=%h want=04", pc); end
        step(1'b0, 1'b0, 1'b0, 8'h00);
        // Asynchronous reset between edges must act immediately.
        #2;
        rst = 1'b0;
        #1;
        total++; if (pc !== 8'h00) begin bad++; $display("FAIL async_pc got=%h want=00", pc); end
        total++; if (if_id_valid !== 1'b0) begin bad++; $display("FAIL async_valid got=%b want=0", if_id_valid); end
        total++; if (bus.imem_addr !== 8'h00) begin bad++; $display("FAIL async_addr got=%h want=00", bus.imem_addr); end
        model_reset();
        @(posedge clk); #1; rst = 1'b1;
    endtask

    task automatic test_stall();
        fill_seq();
        do_reset();
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 1'b0, 8'h00);
            total++; if (pc !== 8'h06) begin bad++; $display("FAIL stall_pc[%0d] got=%h want=06", i, pc); end
            total++; if (if_id_instr !== 16'h1004) begin bad++; $display("FAIL stall_instr[%0d] got=%h want=1004", i, if_id_instr); end
        end
        step(1'b0, 1'b0, 1'b0, 8'h00);
        total++; if (if_id_instr !== 16'h1006) begin bad++; $display("FAIL unstall_instr got=%h want=1006", if_id_instr); end
        total++; if (pc !== 8'h08) begin bad++; $display("FAIL unstall_pc got=%h want=08", pc); end
    endtask

    task automatic test_branch();
        fill_seq();
        do_reset();
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0, 8'h00);
        step(1'b1, 1'b0, 1'b1, 8'h21);
        total++; if (pc !== 8'h20) begin bad++; $display("FAIL br_pc got=%h want=20", pc); end
        total++; if (if_id_valid !== 1'b0) begin bad++; $display("FAIL br_valid got=%b want=0", if_id_valid); end
        total++; if (if_id_instr !== 16'h0000) begin bad++; $display("FAIL br_instr got=%h want=0000", if_id_instr); end
        step(1'b0, 1'b0, 1'b0, 8'h00);
        total++; if (if_id_instr !== 16'h1020) begin bad++; $display("FAIL br_next_instr got=%h want=1020", if_id_instr); end
        total++; if (pc !== 8'h22) begin bad++; $display("FAIL br_next_pc got=%h want=22", pc); end
    endtask

    task automatic test_flush();
        fill_seq();
        do_reset();
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b1, 1'b0, 8'h00);
        total++; if (pc !== 8'h12) begin bad++; $display("FAIL flush_pc got=%h want=12", pc); end
        total++; if (if_id_valid !== 1'b0) begin bad++; $display("FAIL flush_valid got=%b want=0", if_id_valid); end
        do_reset();
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b0, 8'h00);
        step(1'b1, 1'b1, 1'b0, 8'h00);
        total++; if (pc !== 8'h10) begin bad++; $display("FAIL stflush_pc got=%h want=10", pc); end
        total++; if (if_id_valid !== 1'b0) begin bad++; $display("FAIL stflush_valid got=%b want=0", if_id_valid); end
    endtask

    task automatic test_halt();
        fill_seq();
        imem[8'h0C] = 16'hF000;
        do_reset();
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 1'b0, 8'h00);
        total++; if (halted !== 1'b1) begin bad++; $display("FAIL halt_flag got=%b want=1", halted); end
        total++; if (if_id_instr !== 16'hF000) begin bad++; $display("FAIL halt_instr got=%h want=F000", if_id_instr); end
        total++; if (if_id_valid !== 1'b1) begin bad++; $display("FAIL halt_valid got=%b want=1", if_id_valid); end
        total++; if (pc !== 8'h0C) begin bad++; $display("FAIL halt_pc got=%h want=0C", pc); end
        for (int i = 0; i < 2; i++) begin
            step(1'b0, 1'b0, 1'b0, 8'h00);
            total++; if (if_id_valid !== 1'b0) begin bad++; $display("FAIL halted_valid[%0d] got=%b want=0", i, if_id_valid); end
            total++; if (pc !== 8'h0C) begin bad++; $display("FAIL halted_pc[%0d] got=%h want=0C", i, pc); end
        end
        step(1'b1, 1'b1, 1'b0, 8'h00);
        total++; if (halted !== 1'b1) begin bad++; $display("FAIL halt_stall_flag got=%b want=1", halted); end
        step(1'b0, 1'b1, 1'b0, 8'h00);
        total++; if (halted !== 1'b1) begin bad++; $display("FAIL halt_flush_flag got=%b want=1", halted); end
        total++; if (pc !== 8'h0C) begin bad++; $display("FAIL halt_flush_pc got=%h want=0C", pc); end
        step(1'b0, 1'b0, 1'b1, 8'h30);
        total++; if (halted !== 1'b0) begin bad++; $display("FAIL unhalt_flag got=%b want=0", halted); end
        total++; if (pc !== 8'h30) begin bad++; $display("FAIL unhalt_pc got=%h want=30", pc); end
        step(1'b0, 1'b0, 1'b0, 8'h00);
        total++; if (if_id_instr !== 16'h1030) begin bad++; $display("FAIL unhalt_instr got=%h want=1030", if_id_instr); end
    endtask

    task automatic test_wrap();
        fill_seq();
        imem[8'hFE] = 16'h2001;
        do_reset();
        step(1'b0, 1'b0, 1'b1, 8'hFE);
        total++; if (pc !== 8'hFE) begin bad++; $display("FAIL wrap_br_pc got=%h want=FE", pc); end
        step(1'b0, 1'b0, 1'b0, 8'h00);
        total++; if (pc !== 8'h00) begin bad++; $display("FAIL wrap_pc got=%h want=00", pc); end
        total++; if (if_id_pc_plus !== 8'h00) begin bad++; $display("FAIL wrap_pcplus got=%h want=00", if_id_pc_plus); end
        total++; if (if_id_instr !== 16'h2001) begin bad++; $display("FAIL wrap_instr got=%h want=2001", if_id_instr); end
    endtask

    task automatic test_random();
        logic s, f, b;
        logic [7:0] t;
        for (int i = 0; i < 256; i++) imem[i] = 16'($urandom);
        do_reset();
        for (int n = 0; n < 400; n++) begin
            s = ($urandom_range(0, 3) == 0);
            f = ($urandom_range(0, 5) == 0);
            b = ($urandom_range(0, 7) == 0);
            t = 8'($urandom);
            step(s, f, b, t);
            total++; if (pc !== m_pc) begin bad++; $display("FAIL rnd_pc[%0d] got=%h want=%h", n, pc, m_pc); end
            total++; if (bus.imem_addr !== m_pc) begin bad++; $display("FAIL rnd_addr[%0d] got=%h want=%h", n, bus.imem_addr, m_pc); end
            total++; if (if_id_valid !== m_valid) begin bad++; $display("FAIL rnd_valid[%0d] got=%b want=%b", n, if_id_valid, m_valid); end
            total++; if (if_id_instr !== m_instr) begin bad++; $display("FAIL rnd_instr[%0d] got=%h want=%h", n, if_id_instr, m_instr); end
            total++; if (halted !== m_halt) begin bad++; $display("FAIL rnd_halted[%0d] got=%b want=%b", n, halted, m_halt); end
            if (m_valid) begin
                total++; if (if_id_pc_plus !== m_pcp) begin bad++; $display("FAIL rnd_pcplus[%0d] got=%h want=%h", n, if_id_pc_plus, m_pcp); end
            end
        end
    endtask

    initial begin
        rst = 1'b0; stall = 1'b0; flush = 1'b0; branch_taken = 1'b0; branch_target = 8'h00;
        test_reset();
        test_stall();
        test_branch();
        test_flush();
        test_halt();
        test_wrap();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
